seq_det_param: RTL

Parametrised serial pattern detector. It is the successor to the fixed 4-bit "1010" Mealy detector.
- Pattern width is set at elaboration; the pattern value is runtime-loadable.
- Overlapping or non-overlapping detection is selectable by parameter, as is Mealy or Moore output timing.
- A saturating match counter is included.
- Sits on a serial bit stream (`d_in`), qualified by `en`, inside protocol front-ends.

---
 rtl/sat_counter.sv | 46 ++++
 rtl/seq_det_param.sv | 93 +++++++++
 2 files changed

// File: rtl/sat_counter.sv
// Saturating event counter with a sticky "reached all-ones" flag and synchronous clear.
// Clear takes priority over increment so a clear issued alongside an event still yields zero.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q, count_d;
    logic             sat_q, sat_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    always_comb begin
        count_d = count_q;
        sat_d   = sat_q;
        if (clr) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else begin
            if (inc && (count_q != CNT_MAX)) begin
                count_d = count_q + CNT_W'(1);
            end
            sat_d = sat_q | (count_d == CNT_MAX);
        end
    end

    assign count = count_q;
    assign sat   = sat_q;

endmodule

// File: rtl/seq_det_param.sv
// Parametrised serial pattern detector with runtime-loadable pattern, selectable
// overlap and Mealy/Moore output timing, feeding a saturating match counter.
module seq_det_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(4'b1010),
    parameter bit               OVERLAP = 1'b1,
    parameter bit               MEALY   = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             d_in,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern_in,
    input  logic             cnt_clr,
    output logic             seq_det,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int               FILL_W    = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

    typedef enum logic {
        FILLING = 1'b0,
        ARMED   = 1'b1
    } phase_e;

    logic [PAT_W-1:0]  pattern_q, pattern_d;
    logic [PAT_W-2:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              det_q, det_d;

    phase_e            phase;
    logic [PAT_W-1:0]  shifted;
    logic              match;

    // Only PAT_W-1 history bits are kept; the live d_in supplies the last bit of a match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern_q <= PAT_RST;
            hist_q    <= '0;
            fill_q    <= '0;
            det_q     <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            det_q     <= det_d;
        end
    end

    always_comb begin
        pattern_d = pattern_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        det_d     = match;
        if (load) begin
            pattern_d = pattern_in;
            hist_d    = '0;
            fill_d    = '0;
        end else if (en) begin
            if (match && !OVERLAP) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = shifted[PAT_W-2:0];
                fill_d = (fill_q == FILL_LAST) ? fill_q : fill_q + FILL_W'(1);
            end
        end
    end

    // Mealy output is gated by rst so it drops the instant reset is applied.
    always_comb begin
        phase   = (fill_q == FILL_LAST) ? ARMED : FILLING;
        shifted = {hist_q, d_in};
        match   = (phase == ARMED) && en && !load && (shifted == pattern_q);
        seq_det = MEALY ? (match && !rst) : det_q;
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (match),
        .clr   (cnt_clr),
        .count (match_cnt),
        .sat   (cnt_sat)
    );

endmodule
